// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer: fetch (T0-T1), decode/address (T2-T3), execute (T4-T6).
// IDLE wait for run | T0 AR<-PC | T1 fetch | T2 AR<-IR | T3 indirect | T4 operand/store | T5 ALU | T6 writeback
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] ir,
    input  logic       mem_ready,
    output logic       ldAR,
    output logic       ldPC,
    output logic       ldDR,
    output logic       ldAC,
    output logic       ldIR,
    output logic       incPC,
    output logic       rstPC,
    output logic [2:0] busSel,
    output logic [2:0] aluOp,
    output logic       memRead,
    output logic       memWrite,
    output logic [7:0] t,
    output logic       busy,
    output logic [7:0] icount
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7
    } state_t;

    localparam logic [2:0] BUS_AR  = 3'd0;
    localparam logic [2:0] BUS_PC  = 3'd1;
    localparam logic [2:0] BUS_AC  = 3'd3;
    localparam logic [2:0] BUS_IR  = 3'd4;
    localparam logic [2:0] BUS_MEM = 3'd5;
    localparam logic [2:0] OP_STORE = 3'd5;

    state_t     state, state_next;
    logic       retire;
    logic [2:0] opcode;
    logic       unused_ir;

    assign opcode    = ir[6:4];
    assign unused_ir = ^ir[3:0];
    assign rstPC     = rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            icount <= 8'd0;
        end else begin
            state <= state_next;
            if (retire)
                icount <= icount + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        ldAR       = 1'b0;
        ldPC       = 1'b0;
        ldDR       = 1'b0;
        ldAC       = 1'b0;
        ldIR       = 1'b0;
        incPC      = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        busSel     = BUS_AR;
        aluOp      = 3'd0;
        case (state)
            S_IDLE: if (run) state_next = S_T0;
            S_T0: begin
                busSel     = BUS_PC;
                ldAR       = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                busSel  = BUS_MEM;
                memRead = 1'b1;
                if (mem_ready) begin
                    ldIR       = 1'b1;
                    incPC      = 1'b1;
                    state_next = S_T2;
                end
            end
            S_T2: begin
                busSel     = BUS_IR;
                ldAR       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (ir[7]) begin
                    busSel  = BUS_MEM;
                    memRead = 1'b1;
                    if (mem_ready) begin
                        ldAR       = 1'b1;
                        state_next = S_T4;
                    end
                end else begin
                    state_next = S_T4;
                end
            end
            S_T4: begin
                if (opcode == OP_STORE) begin
                    busSel   = BUS_AC;
                    memWrite = 1'b1;
                    retire   = mem_ready;
                end else begin
                    busSel  = BUS_MEM;
                    memRead = 1'b1;
                    if (mem_ready) begin
                        ldDR       = 1'b1;
                        state_next = S_T5;
                    end
                end
            end
            S_T5: begin
                aluOp = opcode;
                ldAC  = 1'b1;
                // SHIFT, CMP and SQRT write their result back to memory
                if (opcode == 3'd3 || opcode == 3'd6 || opcode == 3'd7)
                    state_next = S_T6;
                else
                    retire = 1'b1;
            end
            S_T6: begin
                busSel   = BUS_AC;
                memWrite = 1'b1;
                retire   = mem_ready;
            end
            default: state_next = S_IDLE;
        endcase
        if (retire)
            state_next = run ? S_T0 : S_IDLE;
    end

    always_comb begin
        t = 8'd0;
        case (state)
            S_T0:    t[0] = 1'b1;
            S_T1:    t[1] = 1'b1;
            S_T2:    t[2] = 1'b1;
            S_T3:    t[3] = 1'b1;
            S_T4:    t[4] = 1'b1;
            S_T5:    t[5] = 1'b1;
            S_T6:    t[6] = 1'b1;
            default: t    = 8'd0;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle vector table plus hand-written
// sequences for memory waits, async reset, run-to-first-fetch and icount wrap.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] ir;
    logic       mem_ready;
    logic       ldAR, ldPC, ldDR, ldAC, ldIR, incPC, rstPC;
    logic [2:0] busSel, aluOp;
    logic       memRead, memWrite;
    logic [7:0] t;
    logic       busy;
    logic [7:0] icount;

    int checks = 0;
    int errors = 0;

    control_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .ir(ir), .mem_ready(mem_ready),
        .ldAR(ldAR), .ldPC(ldPC), .ldDR(ldDR), .ldAC(ldAC), .ldIR(ldIR),
        .incPC(incPC), .rstPC(rstPC), .busSel(busSel), .aluOp(aluOp),
        .memRead(memRead), .memWrite(memWrite), .t(t), .busy(busy), .icount(icount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic [7:0] ir;
        logic       rdy;
        logic [7:0] t;
        logic [2:0] bus;
        logic [2:0] alu;
        logic [7:0] strb;   // {ldAR, ldPC, ldDR, ldAC, ldIR, incPC, memRead, memWrite}
        logic       busy;
        logic [7:0] ic;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(logic r, logic [7:0] i, logic rd, logic [7:0] tt,
                                logic [2:0] b, logic [2:0] a, logic [7:0] s,
                                logic bz, logic [7:0] c);
        vec_t v;
        v.run = r; v.ir = i; v.rdy = rd; v.t = tt; v.bus = b; v.alu = a;
        v.strb = s; v.busy = bz; v.ic = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (memRead && memWrite) begin
            errors++;
            $display("FAIL mem_exclusive: memRead and memWrite both high at %0t", $time);
        end
    end

    logic [7:0] strb_now;
    assign strb_now = {ldAR, ldPC, ldDR, ldAC, ldIR, incPC, memRead, memWrite};

    initial begin
        int t1c, t6c, ldir_n, mw6, cyc;
        logic done, saw255, wrapped, hit;

        // ADD direct, STORE indirect, then SUB with garbage ir during fetch and run dropped at T4
        vecs[0]  = mk(1, 8'h03, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 8'h03, 1, 8'h01, 1, 0, 8'h80, 1, 0);
        vecs[2]  = mk(1, 8'h03, 1, 8'h02, 5, 0, 8'h0E, 1, 0);
        vecs[3]  = mk(1, 8'h03, 1, 8'h04, 4, 0, 8'h80, 1, 0);
        vecs[4]  = mk(1, 8'h03, 1, 8'h08, 0, 0, 8'h00, 1, 0);
        vecs[5]  = mk(1, 8'h03, 1, 8'h10, 5, 0, 8'h22, 1, 0);
        vecs[6]  = mk(1, 8'h03, 1, 8'h20, 0, 0, 8'h10, 1, 0);
        vecs[7]  = mk(1, 8'hD5, 1, 8'h01, 1, 0, 8'h80, 1, 1);
        vecs[8]  = mk(1, 8'hD5, 1, 8'h02, 5, 0, 8'h0E, 1, 1);
        vecs[9]  = mk(1, 8'hD5, 1, 8'h04, 4, 0, 8'h80, 1, 1);
        vecs[10] = mk(1, 8'hD5, 1, 8'h08, 5, 0, 8'h82, 1, 1);
        vecs[11] = mk(0, 8'hD5, 1, 8'h10, 3, 0, 8'h01, 1, 1);
        vecs[12] = mk(0, 8'hD5, 1, 8'h00, 0, 0, 8'h00, 0, 2);
        vecs[13] = mk(1, 8'hFF, 1, 8'h00, 0, 0, 8'h00, 0, 2);
        vecs[14] = mk(1, 8'hFF, 1, 8'h01, 1, 0, 8'h80, 1, 2);
        vecs[15] = mk(1, 8'hFF, 1, 8'h02, 5, 0, 8'h0E, 1, 2);
        vecs[16] = mk(1, 8'h12, 1, 8'h04, 4, 0, 8'h80, 1, 2);
        vecs[17] = mk(1, 8'h12, 1, 8'h08, 0, 0, 8'h00, 1, 2);
        vecs[18] = mk(0, 8'h12, 1, 8'h10, 5, 0, 8'h22, 1, 2);
        vecs[19] = mk(0, 8'h12, 1, 8'h20, 0, 1, 8'h10, 1, 2);
        vecs[20] = mk(0, 8'h12, 1, 8'h00, 0, 0, 8'h00, 0, 3);

        rst = 1'b1; run = 1'b0; ir = 8'h00; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_t", t, 8'h00);
        chk("reset_busy", busy, 0);
        chk("reset_icount", icount, 8'h00);
        chk("reset_rstPC", rstPC, 1);
        chk("reset_strobes", strb_now, 8'h00);
        chk("reset_busSel", busSel, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rstPC_low", rstPC, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            run = vecs[i].run; ir = vecs[i].ir; mem_ready = vecs[i].rdy;
            #2;
            chk($sformatf("v%0d_t", i), t, vecs[i].t);
            chk($sformatf("v%0d_busSel", i), busSel, vecs[i].bus);
            chk($sformatf("v%0d_aluOp", i), aluOp, vecs[i].alu);
            chk($sformatf("v%0d_strobes", i), strb_now, vecs[i].strb);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d_icount", i), icount, vecs[i].ic);
        end

        // SQRT with memory waits: 3 in T1, 2 in T6; run released right after fetch starts
        @(negedge clk);
        run = 1'b1; ir = 8'h70; mem_ready = 1'b1;
        @(posedge clk);
        t1c = 0; t6c = 0; ldir_n = 0; mw6 = 0; cyc = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            run = 1'b0;
            if (t == 8'h02)      mem_ready = (t1c == 3);
            else if (t == 8'h40) mem_ready = (t6c == 2);
            else                 mem_ready = 1'b1;
            #1;
            if (t != 8'h00 && t != 8'h01) cyc++;
            if (t == 8'h02) begin
                t1c++;
                if (ldIR) ldir_n++;
            end
            if (t == 8'h40) begin
                t6c++;
                if (memWrite) mw6++;
                if (mem_ready) done = 1'b1;
            end
        end
        chk("sqrt_done", done, 1);
        chk("sqrt_t1_cycles", t1c, 4);
        chk("sqrt_ldIR_pulses", ldir_n, 1);
        chk("sqrt_t6_cycles", t6c, 3);
        chk("sqrt_t6_memWrite", mw6, 3);
        chk("sqrt_T1_to_retire", cyc, 11);
        @(negedge clk);
        #2;
        chk("sqrt_idle_t", t, 8'h00);
        chk("sqrt_icount", icount, 8'h04);

        // async reset while T6 waits on memory
        @(negedge clk);
        run = 1'b1; ir = 8'h70; mem_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (t == 8'h40) begin
                mem_ready = 1'b0;
                hit = 1'b1;
            end
        end
        chk("rst_reached_T6", hit, 1);
        #1;
        chk("rst_pre_memWrite", memWrite, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_memWrite", memWrite, 0);
        chk("rst_async_t", t, 8'h00);
        chk("rst_async_icount", icount, 8'h00);
        chk("rst_async_rstPC", rstPC, 1);
        chk("rst_async_strobes", strb_now, 8'h00);
        chk("rst_async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0; mem_ready = 1'b1; ir = 8'h40;

        // no fetch until run, then T0 on the first edge with run=1
        repeat (2) @(negedge clk);
        #2;
        chk("idle_wait_t", t, 8'h00);
        run = 1'b1;
        @(negedge clk);
        #2;
        chk("first_fetch_t", t, 8'h01);

        // 256 back-to-back LOADs wrap icount
        saw255 = 1'b0; wrapped = 1'b0;
        for (int c = 0; c < 2000 && !wrapped; c++) begin
            @(negedge clk);
            if (icount == 8'd255) saw255 = 1'b1;
            if (saw255 && icount == 8'd0) wrapped = 1'b1;
        end
        chk("wrap_saw_255", saw255, 1);
        chk("wrap_to_zero", wrapped, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
